// File: rtl/buffet_arb_pkg.sv
// Shared types and defaults for the buffet memory arbiter.
//   prio_e         : which side wins the next read/write conflict
//   DEFAULT_DATA_W : SRAM word width
//   DEFAULT_ADDR_W : SRAM address width
package buffet_arb_pkg;

    typedef enum logic {
        PRIO_READ  = 1'b0,
        PRIO_WRITE = 1'b1
    } prio_e;

    localparam int unsigned DEFAULT_DATA_W = 64;
    localparam int unsigned DEFAULT_ADDR_W = 9;

endpackage

// File: rtl/buffet_arb_rsp_fifo.sv
// Synchronous response FIFO holding read data until the read scanner takes it.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : synchronous clear, same effect as reset
//   push_i/data_i: enqueue one word
//   pop_i        : dequeue the head word
//   data_o       : head word (valid when !empty_o)
//   empty_o      : no entries stored
//   count_o      : number of stored entries
// Push and pop together on a full FIFO is legal; no bypass from push to data_o.
module buffet_arb_rsp_fifo
    import buffet_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned RSP_DEPTH = 2,
    parameter int unsigned CNT_W     = $clog2(RSP_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign full    = (count_q == CNT_W'(RSP_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // The credit scheme upstream must make these impossible.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i || clr_i)
        !(push_i && full && !pop_i));
    a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i || clr_i)
        !(pop_i && empty_o));

endmodule

// File: rtl/buffet_mem_arbiter.sv
// Arbitrates a single-port SRAM between the buffet write side and read side.
// One memory op per cycle; round-robin on conflict; read data returns through
// a credit-controlled response FIFO with ready/valid backpressure.
// Ports:
//   clk, rst, clk_en, flush                   : clock, sync reset, enable, sync clear
//   wr_req_valid/ready, wr_addr, wr_data       : write request channel
//   rd_req_valid/ready, rd_addr                : read request channel
//   rd_rsp_valid/ready, rd_rsp_data            : read response channel (FIFO head)
//   addr/data/wen/ren_to_mem, data_from_mem    : SRAM macro interface
// Optional: define BUFFET_ARB_PERF_CNT_EN to add saturating 32-bit counters
//   perf_rd_grants, perf_wr_grants, perf_conflicts.
module buffet_mem_arbiter
    import buffet_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_rsp_data,
    output logic              rd_rsp_valid,
    input  logic              rd_rsp_ready,
    output logic [ADDR_W-1:0] addr_to_mem,
    output logic [DATA_W-1:0] data_to_mem,
    output logic              wen_to_mem,
    output logic              ren_to_mem,
`ifdef BUFFET_ARB_PERF_CNT_EN
    output logic [31:0]       perf_rd_grants,
    output logic [31:0]       perf_wr_grants,
    output logic [31:0]       perf_conflicts,
`endif
    input  logic [DATA_W-1:0] data_from_mem
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(RSP_DEPTH + RD_LAT + 1);

    logic              clear;
    prio_e             prio_q, prio_d;
    logic [RD_LAT-1:0] inflight_q, inflight_d;
    logic [OUT_W-1:0]  outstanding;
    logic              credit_ok;
    logic              rd_elig, wr_elig;
    logic              rd_grant, wr_grant;
    logic              push, pop;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign clear = rst | flush;

    always_comb begin
        // Credits cover reads already issued to the SRAM plus data parked in the FIFO.
        outstanding = OUT_W'(fifo_count);
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            outstanding = outstanding + OUT_W'(inflight_q[i]);
        end

        pop       = !fifo_empty & rd_rsp_ready & clk_en & !clear;
        push      = inflight_q[RD_LAT-1] & clk_en & !clear;
        credit_ok = (outstanding < OUT_W'(RSP_DEPTH)) |
                    ((outstanding == OUT_W'(RSP_DEPTH)) & pop);

        rd_elig = rd_req_valid & credit_ok & clk_en & !clear;
        wr_elig = wr_req_valid & clk_en & !clear;

        rd_grant = 1'b0;
        wr_grant = 1'b0;
        prio_d   = prio_q;
        if (rd_elig && wr_elig) begin
            if (prio_q == PRIO_READ) begin
                rd_grant = 1'b1;
                prio_d   = PRIO_WRITE;
            end else begin
                wr_grant = 1'b1;
                prio_d   = PRIO_READ;
            end
        end else begin
            rd_grant = rd_elig;
            wr_grant = wr_elig;
        end

        inflight_d    = '0;
        inflight_d[0] = rd_grant;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            inflight_d[i] = inflight_q[i-1];
        end

        wr_req_ready = wr_grant;
        rd_req_ready = rd_grant;
        wen_to_mem   = wr_grant;
        ren_to_mem   = rd_grant;
        addr_to_mem  = '0;
        data_to_mem  = '0;
        if (wr_grant) begin
            addr_to_mem = wr_addr;
            data_to_mem = wr_data;
        end else if (rd_grant) begin
            addr_to_mem = rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            prio_q     <= PRIO_READ;
            inflight_q <= '0;
        end else if (clk_en) begin
            prio_q     <= prio_d;
            inflight_q <= inflight_d;
        end
    end

    buffet_arb_rsp_fifo #(
        .DATA_W    (DATA_W),
        .RSP_DEPTH (RSP_DEPTH),
        .CNT_W     (CNT_W)
    ) u_rsp_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (flush),
        .push_i  (push),
        .data_i  (data_from_mem),
        .pop_i   (pop),
        .data_o  (rd_rsp_data),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign rd_rsp_valid = !fifo_empty & !clear;

`ifdef BUFFET_ARB_PERF_CNT_EN
    logic [31:0] perf_rd_q, perf_rd_d;
    logic [31:0] perf_wr_q, perf_wr_d;
    logic [31:0] perf_cf_q, perf_cf_d;

    always_comb begin
        perf_rd_d = perf_rd_q;
        perf_wr_d = perf_wr_q;
        perf_cf_d = perf_cf_q;
        if (rd_grant && (perf_rd_q != '1)) perf_rd_d = perf_rd_q + 32'd1;
        if (wr_grant && (perf_wr_q != '1)) perf_wr_d = perf_wr_q + 32'd1;
        if (rd_elig && wr_elig && (perf_cf_q != '1)) perf_cf_d = perf_cf_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            perf_rd_q <= '0;
            perf_wr_q <= '0;
            perf_cf_q <= '0;
        end else begin
            perf_rd_q <= perf_rd_d;
            perf_wr_q <= perf_wr_d;
            perf_cf_q <= perf_cf_d;
        end
    end

    assign perf_rd_grants = perf_rd_q;
    assign perf_wr_grants = perf_wr_q;
    assign perf_conflicts = perf_cf_q;
`endif

endmodule

// File: tb/tb_buffet_mem_arbiter.sv
// Directed bench for buffet_mem_arbiter with a behavioural 1-cycle SRAM.
module tb_buffet_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, clk_en, flush;
    logic        wr_req_valid, wr_req_ready;
    logic [8:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rd_req_valid, rd_req_ready;
    logic [8:0]  rd_addr;
    logic [63:0] rd_rsp_data;
    logic        rd_rsp_valid, rd_rsp_ready;
    logic [8:0]  addr_to_mem;
    logic [63:0] data_to_mem;
    logic        wen_to_mem, ren_to_mem;
    logic [63:0] data_from_mem;
`ifdef BUFFET_ARB_PERF_CNT_EN
    logic [31:0] perf_rd_grants, perf_wr_grants, perf_conflicts;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] sram [512];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wen_to_mem) sram[addr_to_mem] <= data_to_mem;
        if (ren_to_mem) data_from_mem <= sram[addr_to_mem];
    end

    buffet_mem_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .flush         (flush),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_addr       (rd_addr),
        .rd_rsp_data   (rd_rsp_data),
        .rd_rsp_valid  (rd_rsp_valid),
        .rd_rsp_ready  (rd_rsp_ready),
        .addr_to_mem   (addr_to_mem),
        .data_to_mem   (data_to_mem),
        .wen_to_mem    (wen_to_mem),
        .ren_to_mem    (ren_to_mem),
`ifdef BUFFET_ARB_PERF_CNT_EN
        .perf_rd_grants(perf_rd_grants),
        .perf_wr_grants(perf_wr_grants),
        .perf_conflicts(perf_conflicts),
`endif
        .data_from_mem (data_from_mem)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        rd_addr      = '0;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        idle_inputs();
        repeat (2) next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        next_cycle();
        rst          = 1'b1;
        clk_en       = 1'b1;
        flush        = 1'b0;
        rd_rsp_ready = 1'b1;
        wr_req_valid = 1'b1;
        rd_req_valid = 1'b1;
        wr_addr      = 9'h1FF;
        wr_data      = 64'hDEAD;
        rd_addr      = 9'h0AA;
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({wr_req_ready, rd_req_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 00", {wr_req_ready, rd_req_ready});
        end
        n_tests++;
        if ({wen_to_mem, ren_to_mem} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mem_en: got %b expected 00", {wen_to_mem, ren_to_mem});
        end
        n_tests++;
        if (addr_to_mem !== 9'd0 || data_to_mem !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_addr_data: got %0h/%0h expected 0/0", addr_to_mem, data_to_mem);
        end
        n_tests++;
        if (rd_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp_valid: got %b expected 0", rd_rsp_valid);
        end
        next_cycle();
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_write_only();
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            wr_req_valid = 1'b1;
            wr_addr      = 9'(i);
            wr_data      = 64'(160 + i);
            rd_req_valid = 1'b0;
            @(negedge clk);
            n_tests++;
            if ({wr_req_ready, wen_to_mem, ren_to_mem} !== 3'b110) begin
                n_fail++;
                $display("FAIL wr_only_grant[%0d]: got %b expected 110", i,
                         {wr_req_ready, wen_to_mem, ren_to_mem});
            end
            n_tests++;
            if (addr_to_mem !== 9'(i) || data_to_mem !== 64'(160 + i)) begin
                n_fail++;
                $display("FAIL wr_only_addr_data[%0d]: got %0h/%0h expected %0h/%0h", i,
                         addr_to_mem, data_to_mem, i, 160 + i);
            end
            n_tests++;
            if (rd_rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_only_rsp_valid[%0d]: got %b expected 0", i, rd_rsp_valid);
            end
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_read_back();
        logic exp_v;
        rd_rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) next_cycle();
            rd_req_valid = (c < 8);
            rd_addr      = 9'((c < 8) ? c : 0);
            @(negedge clk);
            if (c < 8) begin
                n_tests++;
                if ({rd_req_ready, ren_to_mem, wen_to_mem} !== 3'b110 ||
                    addr_to_mem !== 9'(c)) begin
                    n_fail++;
                    $display("FAIL rd_back_grant[%0d]: got %b addr %0h expected 110 addr %0h",
                             c, {rd_req_ready, ren_to_mem, wen_to_mem}, addr_to_mem, c);
                end
            end
            exp_v = (c >= 2 && c < 10);
            n_tests++;
            if (rd_rsp_valid !== exp_v) begin
                n_fail++;
                $display("FAIL rd_back_valid[%0d]: got %b expected %b", c, rd_rsp_valid, exp_v);
            end else if (exp_v) begin
                n_tests++;
                if (rd_rsp_data !== 64'(160 + c - 2)) begin
                    n_fail++;
                    $display("FAIL rd_back_data[%0d]: got %0h expected %0h", c, rd_rsp_data,
                             160 + c - 2);
                end
            end
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_conflict();
        logic exp_rd;
        do_reset();
        rd_rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) next_cycle();
            wr_req_valid = 1'b1;
            wr_addr      = 9'(16 + c);
            wr_data      = 64'(176 + c);
            rd_req_valid = 1'b1;
            rd_addr      = 9'(c);
            @(negedge clk);
            exp_rd = (c % 2 == 0);
            n_tests++;
            if ({rd_req_ready, wr_req_ready, ren_to_mem, wen_to_mem} !==
                {exp_rd, !exp_rd, exp_rd, !exp_rd}) begin
                n_fail++;
                $display("FAIL conflict_grant[%0d]: got rd/wr/ren/wen %b expected %b", c,
                         {rd_req_ready, wr_req_ready, ren_to_mem, wen_to_mem},
                         {exp_rd, !exp_rd, exp_rd, !exp_rd});
            end
            if (c == 2 || c == 4) begin
                n_tests++;
                if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== 64'(160 + c - 2)) begin
                    n_fail++;
                    $display("FAIL conflict_rsp[%0d]: got %b/%0h expected 1/%0h", c,
                             rd_rsp_valid, rd_rsp_data, 160 + c - 2);
                end
            end
        end
        repeat (4) begin
            next_cycle();
            idle_inputs();
        end
`ifdef BUFFET_ARB_PERF_CNT_EN
        @(negedge clk);
        n_tests++;
        if (perf_conflicts !== 32'd6 || perf_rd_grants !== 32'd3 ||
            perf_wr_grants !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_counts: got cf/rd/wr %0d/%0d/%0d expected 6/3/3",
                     perf_conflicts, perf_rd_grants, perf_wr_grants);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic        exp_rd, exp_wr, exp_v;
        logic [63:0] exp_d;
        rd_rsp_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            idle_inputs();
            if (c < 4) begin
                rd_req_valid = 1'b1;
                rd_addr      = 9'((c < 2) ? c : 2);
            end else if (c < 7) begin
                rd_req_valid = 1'b1;
                rd_addr      = 9'd2;
                wr_req_valid = 1'b1;
                wr_addr      = 9'(32 + c);
                wr_data      = 64'(200 + c);
            end else if (c < 9) begin
                rd_rsp_ready = 1'b1;
                rd_req_valid = 1'b1;
                rd_addr      = 9'(c - 5);
            end
            @(negedge clk);
            exp_rd = (c < 2) || (c == 7) || (c == 8);
            exp_wr = (c >= 4 && c < 7);
            n_tests++;
            if ({rd_req_ready, wr_req_ready, ren_to_mem, wen_to_mem} !==
                {exp_rd, exp_wr, exp_rd, exp_wr}) begin
                n_fail++;
                $display("FAIL bp_grant[%0d]: got rd/wr/ren/wen %b expected %b", c,
                         {rd_req_ready, wr_req_ready, ren_to_mem, wen_to_mem},
                         {exp_rd, exp_wr, exp_rd, exp_wr});
            end
            exp_v = (c >= 2 && c <= 10);
            exp_d = (c <= 7) ? 64'd160 : 64'(160 + c - 7);
            n_tests++;
            if (rd_rsp_valid !== exp_v || (exp_v && rd_rsp_data !== exp_d)) begin
                n_fail++;
                $display("FAIL bp_rsp[%0d]: got %b/%0h expected %b/%0h", c, rd_rsp_valid,
                         rd_rsp_data, exp_v, exp_d);
            end
        end
    endtask

    task automatic test_flush();
        rd_rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            idle_inputs();
            flush = (c == 1);
            if (c < 3) begin
                wr_req_valid = 1'b1;
                wr_addr      = 9'd48;
                wr_data      = 64'hF0;
                rd_req_valid = 1'b1;
                rd_addr      = (c < 2) ? 9'd5 : 9'd6;
            end
            @(negedge clk);
            if (c < 3) begin
                n_tests++;
                if ({rd_req_ready, wr_req_ready, ren_to_mem, wen_to_mem} !==
                    ((c == 1) ? 4'b0000 : 4'b1010)) begin
                    n_fail++;
                    $display("FAIL flush_grant[%0d]: got rd/wr/ren/wen %b expected %b", c,
                             {rd_req_ready, wr_req_ready, ren_to_mem, wen_to_mem},
                             (c == 1) ? 4'b0000 : 4'b1010);
                end
            end
            n_tests++;
            if (rd_rsp_valid !== (c == 4) || (c == 4 && rd_rsp_data !== 64'hA6)) begin
                n_fail++;
                $display("FAIL flush_rsp[%0d]: got %b/%0h expected %b/a6", c, rd_rsp_valid,
                         rd_rsp_data, (c == 4));
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_clk_en();
        // Grant codes: 0 none, 1 read, 2 write.
        int          exp_g;
        logic        exp_v;
        logic [63:0] exp_d;
        rd_rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            idle_inputs();
            clk_en = !(c >= 2 && c <= 4);
            if (c <= 5) begin
                wr_req_valid = 1'b1;
                wr_addr      = 9'(40 + ((c < 2) ? c : 2));
                wr_data      = 64'(192 + ((c < 2) ? c : 2));
            end
            if (c <= 6) begin
                rd_req_valid = 1'b1;
                rd_addr      = (c < 2) ? 9'd7 : 9'd0;
            end
            @(negedge clk);
            case (c)
                0, 5:    exp_g = 2;
                1, 6:    exp_g = 1;
                default: exp_g = 0;
            endcase
            n_tests++;
            if ({rd_req_ready, wr_req_ready, ren_to_mem, wen_to_mem} !==
                {exp_g == 1, exp_g == 2, exp_g == 1, exp_g == 2}) begin
                n_fail++;
                $display("FAIL clk_en_grant[%0d]: got rd/wr/ren/wen %b expected code %0d", c,
                         {rd_req_ready, wr_req_ready, ren_to_mem, wen_to_mem}, exp_g);
            end
            exp_v = (c == 6) || (c == 8);
            exp_d = (c == 6) ? 64'hA7 : 64'hA0;
            n_tests++;
            if (rd_rsp_valid !== exp_v || (exp_v && rd_rsp_data !== exp_d)) begin
                n_fail++;
                $display("FAIL clk_en_rsp[%0d]: got %b/%0h expected %b/%0h", c, rd_rsp_valid,
                         rd_rsp_data, exp_v, exp_d);
            end
        end
        clk_en = 1'b1;
    endtask

    initial begin
        rst          = 1'b1;
        clk_en       = 1'b1;
        flush        = 1'b0;
        rd_rsp_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_write_only();
        test_read_back();
        test_conflict();
        test_backpressure();
        test_flush();
        test_clk_en();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/buffet_mem_arbiter.md
Name: buffet_mem_arbiter

Overview:
- Shares one single-port SRAM (sram_sp, 64-bit words, 9-bit address, 1-cycle read latency) between the write-scanner side and the read-scanner side of a fiber-access tile.
- Round-robin arbitration when both request in the same cycle.
- Issues one memory op per cycle and returns read data through a credit-controlled response FIFO with ready/valid backpressure.
- Sits between the buffet request logic and the SRAM macro ports (addr_to_mem, data_to_mem, wen_to_mem, ren_to_mem, data_from_mem).

Parameters:
DATA_W, 64, SRAM word width
ADDR_W, 9, SRAM address width
RD_LAT, 1, cycles from ren_to_mem to data_from_mem valid
RSP_DEPTH, 2, response FIFO entries (must be >= RD_LAT+1 for full read throughput)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
clk_en  in  1  global enable; low freezes all state and forces wen/ren to 0
flush  in  1  synchronous clear, same effect as rst on arbiter state
wr_req_valid  in  1  write request
wr_req_ready  out  1  write granted this cycle
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_req_valid  in  1  read request
rd_req_ready  out  1  read granted this cycle
rd_addr  in  ADDR_W  read address
rd_rsp_data  out  DATA_W  read response data (FIFO head)
rd_rsp_valid  out  1  response available
rd_rsp_ready  in  1  response consumed
addr_to_mem  out  ADDR_W  SRAM address
data_to_mem  out  DATA_W  SRAM write data
wen_to_mem  out  1  SRAM write enable
ren_to_mem  out  1  SRAM read enable
data_from_mem  in  DATA_W  SRAM read data

Behaviour:
- Reset/flush (sync, either high): FIFO empty, in-flight shift register cleared, prio pointer = READ. Outputs: rd_rsp_valid=0, wen/ren=0, wr_req_ready=0, rd_req_ready=0, addr_to_mem=0, data_to_mem=0. Reset or flush during an in-flight read discards that read; its data is never enqueued.
- Credits: outstanding = popcount(inflight[RD_LAT-1:0]) + fifo_count. credit_ok = outstanding < RSP_DEPTH, or (outstanding == RSP_DEPTH and FIFO pop this cycle).
- Eligibility: rd_elig = rd_req_valid & credit_ok & clk_en; wr_elig = wr_req_valid & clk_en.
- Grant:
  - Only one eligible: grant it.
  - Both eligible: grant the side named by prio; prio flips to the other side.
  - Single-requester grants leave prio unchanged.
- ready/mem outputs are combinational from the grant. Grant depends on the other side's valid, never on its own ready; no combinational loop.
- Write grant: wen_to_mem=1, addr_to_mem=wr_addr, data_to_mem=wr_data.
- Read grant: ren_to_mem=1, addr_to_mem=rd_addr, data_to_mem=0.
- Idle: addr/data held at 0.
- Read pipeline: inflight shifts in the read grant each clk_en cycle. When inflight[RD_LAT-1]=1, data_from_mem is enqueued the same edge. Credit rule guarantees no overflow; overflow is an assertion failure.
- FIFO:
  - rd_rsp_valid = !empty; rd_rsp_data = head.
  - Pop on rd_rsp_valid & rd_rsp_ready.
  - Simultaneous push and pop on a full FIFO is legal.
  - Push into an empty FIFO appears on rd_rsp_valid the next cycle (no bypass). Total read latency is RD_LAT+1 cycles from grant to rd_rsp_valid.
- clk_en=0: no grant, no shift, no push/pop, all registers hold.

Optional Feature:
- Macro: BUFFET_ARB_PERF_CNT_EN.
- When defined, adds 32-bit outputs perf_rd_grants, perf_wr_grants and perf_conflicts.
  - Each saturates at 2^32-1 and clears on rst/flush.
  - perf_conflicts increments when wr_elig & rd_elig.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package buffet_arb_pkg: enum prio_e {PRIO_READ, PRIO_WRITE}; localparams DEFAULT_DATA_W=64, DEFAULT_ADDR_W=9.
- One sub-module, buffet_arb_rsp_fifo: parameterised DATA_W/RSP_DEPTH sync FIFO with count output.
- Arbitration, credit and inflight logic stay in the top module.

Test Plan:
1. Reset, then write-only: wr addr 0..7 with data 0xA0+i, rd idle -> wr_req_ready=1 every cycle, wen_to_mem 8 consecutive cycles, rd_rsp_valid stays 0.
2. Read-back, rd_rsp_ready=1: rd addr 0..7 -> 8 back-to-back grants; rd_rsp_data 0xA0..0xA7 in order, first arriving 2 cycles after the first grant.
3. Conflict: wr and rd both valid for 6 cycles after reset -> grants R,W,R,W,R,W; perf_conflicts=6 when BUFFET_ARB_PERF_CNT_EN is defined.
4. Backpressure: rd_rsp_ready=0, rd_req_valid held high -> exactly RSP_DEPTH=2 grants, then rd_req_ready=0 while wr still gets every cycle. Releasing ready -> data drains in order, no loss or duplication.
5. Flush mid-read: assert flush the cycle after a read grant -> rd_rsp_valid never rises for that read, FIFO empty, prio=READ.
6. clk_en low for 3 cycles with both requests valid -> no wen/ren, FIFO and prio unchanged; sequence resumes identically once clk_en returns high.
